// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm arm/disarm sequencer with exit/entry delays and siren timing
//
// Ports:
//   clock50      in   board clock, all logic on its rising edge
//   Mr           in   synchronous active-high master reset
//   arm          in   arm request pulse
//   code_ok      in   valid disarm code pulse
//   tamper       in   tamper switch level
//   sensor       in   zone sensor levels (1 = open)
//   state        out  encoded current state
//   blink_en     out  status blinker enable
//   siren        out  siren drive
//   armed_led    out  steady armed indicator
//   zone_latched out  zones that caused the trip
module alarm_sequencer #(
  parameter int TICK_DIV    = 50000000,
  parameter int EXIT_TICKS  = 30,
  parameter int ENTRY_TICKS = 15,
  parameter int SIREN_TICKS = 180,
  parameter int ZONES       = 4
) (
  input  logic             clock50,
  input  logic             Mr,
  input  logic             arm,
  input  logic             code_ok,
  input  logic             tamper,
  input  logic [ZONES-1:0] sensor,
  output logic [2:0]       state,
  output logic             blink_en,
  output logic             siren,
  output logic             armed_led,
  output logic [ZONES-1:0] zone_latched
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  localparam int MAXT_A = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
  localparam int MAXT   = (MAXT_A > SIREN_TICKS) ? MAXT_A : SIREN_TICKS;
  localparam int TW     = $clog2(TICK_DIV);
  localparam int DW     = $clog2(MAXT + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] EXIT_LAST  = DW'(EXIT_TICKS - 1);
  localparam logic [DW-1:0] ENTRY_LAST = DW'(ENTRY_TICKS - 1);
  localparam logic [DW-1:0] SIREN_LAST = DW'(SIREN_TICKS - 1);

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]    delay_cnt_q, delay_cnt_d;
  logic [ZONES-1:0] zone_q, zone_d;
  logic             siren_q, siren_d;
  logic             blink_en_q, blink_en_d;
  logic             armed_led_q, armed_led_d;

  logic             tick;
  logic             timed;
  logic             expire;
  logic [DW-1:0]    limit;

  always_comb begin
    tick  = (tick_cnt_q == TICK_LAST);
    limit = SIREN_LAST;
    case (state_q)
      S_EXIT:  limit = EXIT_LAST;
      S_ENTRY: limit = ENTRY_LAST;
      default: limit = SIREN_LAST;
    endcase
    // ALARM only times while the siren is still sounding; afterwards the
    // counters freeze so the silent alarm never wraps back into a siren.
    timed  = (state_q == S_EXIT) || (state_q == S_ENTRY) ||
             ((state_q == S_ALARM) && siren_q);
    expire = timed && tick && (delay_cnt_q == limit);
  end

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    if (state_q > 3'd4) begin
      state_d = S_DISARMED;
    end else if (tamper) begin
      state_d = S_ALARM;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm) begin
            state_d = S_EXIT;
            zone_d  = '0;
          end
        end
        S_EXIT: begin
          if (code_ok)     state_d = S_DISARMED;
          else if (expire) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (code_ok) begin
            state_d = S_DISARMED;
          end else if (|sensor) begin
            state_d = S_ENTRY;
            zone_d  = zone_q | sensor;
          end
        end
        S_ENTRY: begin
          if (code_ok) begin
            state_d = S_DISARMED;
          end else begin
            zone_d = zone_q | sensor;
            if (expire) state_d = S_ALARM;
          end
        end
        S_ALARM: begin
          if (code_ok) state_d = S_DISARMED;
        end
        default: state_d = S_DISARMED;
      endcase
    end
  end

  // Counters restart on every state change so each interval is aligned to
  // state entry; they hold on expiry so ALARM stops counting once silent.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    delay_cnt_d = delay_cnt_q;
    if (state_d != state_q) begin
      tick_cnt_d  = '0;
      delay_cnt_d = '0;
    end else if (timed && !expire) begin
      if (tick) begin
        tick_cnt_d  = '0;
        delay_cnt_d = delay_cnt_q + 1'b1;
      end else begin
        tick_cnt_d  = tick_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    siren_d = siren_q;
    if (state_d != S_ALARM)      siren_d = 1'b0;
    else if (state_q != S_ALARM) siren_d = 1'b1;
    else if (expire)             siren_d = 1'b0;
    blink_en_d  = (state_d == S_EXIT) || (state_d == S_ENTRY) || (state_d == S_ALARM);
    armed_led_d = (state_d == S_ARMED) || (state_d == S_ENTRY);
  end

  always_ff @(posedge clock50) begin
    if (Mr) begin
      state_q     <= S_DISARMED;
      tick_cnt_q  <= '0;
      delay_cnt_q <= '0;
      zone_q      <= '0;
      siren_q     <= 1'b0;
      blink_en_q  <= 1'b0;
      armed_led_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      zone_q      <= zone_d;
      siren_q     <= siren_d;
      blink_en_q  <= blink_en_d;
      armed_led_q <= armed_led_d;
    end
  end

  assign state        = state_q;
  assign blink_en     = blink_en_q;
  assign siren        = siren_q;
  assign armed_led    = armed_led_q;
  assign zone_latched = zone_q;

endmodule
